// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader FSM state encoding and instruction width.
`default_nettype none

package imem_loader_pkg;

  localparam int c_instr_w = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_byte_assembler.sv
// ------------------------------------------------------------------
// imem_byte_assembler: collects little-endian bytes into 32-bit words.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module imem_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_clr,
  input  logic                 i_accept,
  input  logic [7:0]           i_byte,
  output logic [c_instr_w-1:0] o_word,
  output logic                 o_word_done
);

  logic [1:0]  r_byte_idx;
  logic [23:0] r_lanes;

  // The fourth byte is merged combinationally so the top can register the word on its accept edge.
  assign o_word      = {i_byte, r_lanes};
  assign o_word_done = i_accept && (r_byte_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_byte_idx <= 2'd0;
      r_lanes    <= 24'd0;
    end else if (i_clr) begin
      r_byte_idx <= 2'd0;
    end else if (i_accept) begin
      r_byte_idx <= r_byte_idx + 2'd1;
      case (r_byte_idx)
        2'd0:    r_lanes[7:0]   <= i_byte;
        2'd1:    r_lanes[15:8]  <= i_byte;
        2'd2:    r_lanes[23:16] <= i_byte;
        default: r_lanes        <= r_lanes;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ------------------------------------------------------------------
// imem_loader: length-prefixed byte-stream boot loader for instruction memory.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MEM_BYTES = 128,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [63:0]          wr_addr,
  output logic [c_instr_w-1:0] wr_data,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error
);

  localparam logic [15:0] c_max_words = 16'(MEM_BYTES / 4);

  loader_state_t r_state, w_next;

  logic [7:0]           r_len_lo;
  logic [15:0]          r_word_cnt;
  logic [15:0]          r_word_idx;
  logic                 r_wr_en;
  logic [63:0]          r_wr_addr;
  logic [c_instr_w-1:0] r_wr_data;

  logic                 w_accept;
  logic                 w_start_load;
  logic                 w_data_accept;
  logic [15:0]          w_len;
  logic [c_instr_w-1:0] w_word;
  logic                 w_word_done;
  logic                 w_last_word;
  loader_state_t        w_tail_state;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  assign w_tail_state = ST_CSUM;
`else
  assign w_tail_state = ST_DONE;
`endif

  assign in_ready = ((r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                     (r_state == ST_DATA)   || (r_state == ST_CSUM)) && !r_wr_en;
  assign w_accept      = in_valid && in_ready;
  assign w_data_accept = w_accept && (r_state == ST_DATA);
  assign w_start_load  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERROR));
  assign w_len         = {in_data, r_len_lo};
  assign w_last_word   = (r_word_idx + 16'd1) == r_word_cnt;

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign done     = (r_state == ST_DONE);
  assign error    = (r_state == ST_ERROR);
  assign cpu_hold = (r_state != ST_DONE);

  imem_byte_assembler u_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clr      (w_start_load),
    .i_accept   (w_data_accept),
    .i_byte     (in_data),
    .o_word     (w_word),
    .o_word_done(w_word_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) w_next = ST_LEN_LO;
      ST_LEN_LO: if (w_accept) w_next = ST_LEN_HI;
      ST_LEN_HI: begin
        if (w_accept) begin
          if (w_len == 16'd0)            w_next = w_tail_state;
          else if (w_len > c_max_words)  w_next = ST_ERROR;
          else                           w_next = ST_DATA;
        end
      end
      ST_DATA: if (w_word_done && w_last_word) w_next = w_tail_state;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: if (w_accept) w_next = (in_data == r_csum) ? ST_DONE : ST_ERROR;
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_len_lo   <= 8'd0;
      r_word_cnt <= 16'd0;
      r_word_idx <= 16'd0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 64'd0;
      r_wr_data  <= '0;
    end else begin
      r_state <= w_next;
      r_wr_en <= w_word_done;
      if (w_start_load)
        r_word_idx <= 16'd0;
      if (w_accept && (r_state == ST_LEN_LO))
        r_len_lo <= in_data;
      if (w_accept && (r_state == ST_LEN_HI))
        r_word_cnt <= w_len;
      if (w_word_done) begin
        r_wr_addr  <= BASE_ADDR + {46'd0, r_word_idx, 2'b00};
        r_wr_data  <= w_word;
        r_word_idx <= r_word_idx + 16'd1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_csum <= 8'd0;
    else if (w_start_load)
      r_csum <= 8'd0;
    else if (w_data_accept)
      r_csum <= r_csum ^ in_data;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed streams with a write scoreboard for imem_loader.
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_assert = 0;
  int n_fail   = 0;

  logic [95:0] exp_q[$];

  imem_loader #(.MEM_BYTES(128), .BASE_ADDR(64'd0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the oldest expected write.
  always @(negedge clk) begin
    if (wr_en) begin
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        if (wr_addr !== e[95:32] || wr_data !== e[31:0]) begin
          n_fail++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   wr_addr, wr_data, e[95:32], e[31:0]);
        end
      end
      n_assert++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_during_write: got %0b expected 0", in_ready);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    if (gap) begin
      @(negedge clk); in_valid = 1'b0; in_data = 8'hxx;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_assert++; n_fail++;
      $display("FAIL byte_timeout: got no accept expected accept of %0h", b);
    end
  endtask

  task automatic end_stream();
    @(negedge clk); in_valid = 1'b0; in_data = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  task automatic load_one_word();
    pulse_start();
    exp_q.push_back({64'd0, 32'h00100213});
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(32'h00100213, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h01, 0);
`endif
    end_stream();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_hold"}, {63'd0, cpu_hold}, 64'd0);
    check({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, in_ready}, 64'd0);
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_addr", wr_addr, 64'd0);
    check("rst_data", {32'd0, wr_data}, 64'd0);
    check("rst_hold", {63'd0, cpu_hold}, 64'd1);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {63'd0, in_ready}, 64'd0);

    // Single word load
    load_one_word();
    check_done("t1");

    // Three words with in_valid gapping every other cycle
    pulse_start();
    check("t2_done_cleared", {63'd0, done}, 64'd0);
    check("t2_hold_set", {63'd0, cpu_hold}, 64'd1);
    exp_q.push_back({64'd0, 32'h00100213});
    exp_q.push_back({64'd4, 32'h001202b3});
    exp_q.push_back({64'd8, 32'h00343023});
    send_byte(8'h03, 1); send_byte(8'h00, 1);
    send_word(32'h00100213, 1);
    send_word(32'h001202b3, 1);
    send_word(32'h00343023, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h85, 1);
`endif
    end_stream();
    repeat (2) @(negedge clk);
    check_done("t2");
    check("t2_last_addr_hold", wr_addr, 64'd8);
    check("t2_last_data_hold", {32'd0, wr_data}, 64'h00343023);

    // Zero-length image
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    end_stream();
    check("t3_done", {63'd0, done}, 64'd1);
    check("t3_hold", {63'd0, cpu_hold}, 64'd0);

    // Oversized image, then recovery
    pulse_start();
    send_byte(8'h21, 0); send_byte(8'h00, 0);
    end_stream();
    check("t4_error", {63'd0, error}, 64'd1);
    check("t4_hold", {63'd0, cpu_hold}, 64'd1);
    check("t4_ready", {63'd0, in_ready}, 64'd0);
    check("t4_done", {63'd0, done}, 64'd0);
    load_one_word();
    check("t4_error_cleared", {63'd0, error}, 64'd0);
    check_done("t4r");

    // Reset in the middle of word 1
    pulse_start();
    exp_q.push_back({64'd0, 32'h00100213});
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h00100213, 0);
    send_byte(8'hb3, 0); send_byte(8'h02, 0);
    end_stream();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_rst_addr", wr_addr, 64'd0);
    check("t5_rst_hold", {63'd0, cpu_hold}, 64'd1);
    check("t5_pending", 64'(exp_q.size()), 64'd0);
    reset_n = 1'b1;
    load_one_word();
    check_done("t5");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum: word is written but load ends in error
    pulse_start();
    exp_q.push_back({64'd0, 32'h00100213});
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(32'h00100213, 0);
    send_byte(8'h00, 0);
    end_stream();
    check("t6_error", {63'd0, error}, 64'd1);
    check("t6_hold", {63'd0, cpu_hold}, 64'd1);
    check("t6_pending", 64'(exp_q.size()), 64'd0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream boot loader: the write-side counterpart of the processor's read-only, byte-addressed instruction memory.
- Receives a length-prefixed little-endian program image over a valid/ready byte interface and assembles it into 32-bit instruction words.
- Issues one registered word write per instruction into the instruction memory write port.
- Holds the pipelined core in reset (cpu_hold) until the image is completely loaded.

Parameters:
- MEM_BYTES, 128, instruction memory size in bytes; must be a multiple of 4.
- BASE_ADDR, 0, byte address of the first instruction word (word-aligned).

Ports:
- clk  in  1  core clock.
- reset_n  in  1  synchronous, active-low reset (sampled on rising clk edge).
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR; ignored while loading.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte when in_valid && in_ready on a rising edge.
- wr_en  out  1  one-cycle instruction memory write strobe.
- wr_addr  out  64  byte address of the written word (matches the 64-bit fetch address width).
- wr_data  out  32  instruction word; bits [7:0] are the first received byte.
- cpu_hold  out  1  holds the core in reset while high.
- done  out  1  load completed successfully; level signal.
- error  out  1  load aborted; level signal.

Behaviour:
- Reset values (reset_n low at an edge): state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, cpu_hold 1, done 0, error 0, all counters 0.
- Reset mid-load abandons the transfer; memory contents already written are not reverted.
- Stream format: LEN_LO, LEN_HI (word count N, 16-bit LE), then 4*N data bytes in LE order per word.
- States and transitions:
  - IDLE: start -> LEN_LO.
  - LEN_LO: on byte accept -> LEN_HI.
  - LEN_HI: on byte accept:
    - N == 0 -> DONE.
    - N > MEM_BYTES/4 -> ERROR.
    - otherwise -> DATA.
  - DATA: on each byte accept, store the byte in lane byte_idx, then byte_idx wraps 3 -> 0.
    - On the 4th byte, the next cycle drives wr_en=1, wr_addr=BASE_ADDR+4*word_idx, wr_data=assembled word; word_idx increments.
    - When the write of word N-1 is issued, the state moves to DONE in the same cycle.
  - DONE: done=1, cpu_hold=0, in_ready=0; start -> LEN_LO (done cleared, cpu_hold=1).
  - ERROR: error=1, cpu_hold=1, in_ready=0; start -> LEN_LO (error cleared).
- in_ready is 1 only in LEN_LO, LEN_HI and DATA (plus CSUM when the optional feature is present).
  - It drops to 0 in the cycle wr_en is high, so at most one write is in flight.
  - Maximum throughput is 4 bytes per 5 cycles.
- start while loading (LEN_LO/LEN_HI/DATA/CSUM) is ignored.
- start coinciding with a byte accept in DONE/ERROR is impossible (in_ready=0 there).
- in_data is ignored when in_valid=0; in_valid may drop between bytes with no effect on state.
- wr_addr/wr_data hold their last values when wr_en=0.
- Address arithmetic is 64-bit unsigned; word_idx is 16 bits.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of all data bytes (length bytes excluded) is kept.
  - After the last word write (or after LEN_HI when N == 0), the state moves to CSUM and accepts one checksum byte.
  - Match -> DONE; mismatch -> ERROR.
  - Words are already written on mismatch; cpu_hold stays 1.
- Undefined: no CSUM state; the last word write goes directly to DONE; the stream carries no checksum byte.

Decomposition:
- Shared package: state encoding constants (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR) and the RV instruction width constant (32).
- One natural sub-module, imem_byte_assembler: byte_idx counter, 4-lane shift/assemble register and word-complete pulse.
- The top level keeps the FSM, word counter, write port and checksum.

Test Plan:
- Reset then start, stream 01 00 13 02 10 00 -> one wr_en pulse: wr_addr=0, wr_data=32'h00100213; then done=1, cpu_hold=0.
- Load N=3 words (h00100213, h001202b3, h00343023) with in_valid toggling every other cycle -> writes at addresses 0, 4, 8 with the correct words; in_ready=0 during each wr_en cycle.
- N=0 (stream 00 00) -> no wr_en; done=1 two byte-accepts after start.
- N=33 with MEM_BYTES=128 -> ERROR after LEN_HI, error=1, cpu_hold=1, in_ready=0; a new start recovers and a valid load completes.
- reset_n low after the 2nd data byte of word 1, then release and restart -> no partial write; a fresh load writes from wr_addr=0.
- IMEM_LOADER_CHECKSUM_EN: N=1, word h00100213, checksum 8'h01 -> DONE; checksum 8'h00 -> ERROR after the word write.
